// File: rtl/sram_wb_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_wb_port_ctrl
//
// Wishbone-classic slave front-end for port 0 (RW) of the 32x512 OpenRAM macro.
// Every macro port-0 input comes straight from a flop, so the macro sees clean
// signals at its posedge capture. Read data is captured from the macro and
// returned with a single-cycle ack. Port 1 is parked idle.
//
// Ports
//   wb_clk_i     in   1        single clock; also forwarded to sram_clk0/1
//   wb_rst_i     in   1        synchronous reset, active high
//   wbs_cyc_i    in   1        bus cycle
//   wbs_stb_i    in   1        strobe
//   wbs_we_i     in   1        1 = write
//   wbs_sel_i    in   4        byte lanes
//   wbs_adr_i    in   32       byte address
//   wbs_dat_i    in   32       write data
//   wbs_ack_o    out  1        transfer done, one cycle
//   wbs_dat_o    out  32       read data while wbs_ack_o=1, else 0
//   sram_clk0    out  1        macro port-0 clock (= wb_clk_i)
//   sram_csb0    out  1        macro port-0 chip select, active low
//   sram_web0    out  1        macro port-0 write enable, active low
//   sram_wmask0  out  4        macro byte mask
//   sram_addr0   out  SRAM_AW  macro word address
//   sram_din0    out  32       macro write data
//   sram_dout0   in   32       macro read data
//   sram_clk1    out  1        macro port-1 clock (= wb_clk_i)
//   sram_csb1    out  1        port-1 chip select, held deselected
//   sram_addr1   out  SRAM_AW  port-1 address, held at 0
// -----------------------------------------------------------------------------
module sram_wb_port_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_F800,
   parameter int          SRAM_AW   = 9
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic               sram_clk0,
   output logic               sram_csb0,
   output logic               sram_web0,
   output logic [3:0]         sram_wmask0,
   output logic [SRAM_AW-1:0] sram_addr0,
   output logic [31:0]        sram_din0,
   input  logic [31:0]        sram_dout0,
   output logic               sram_clk1,
   output logic               sram_csb1,
   output logic [SRAM_AW-1:0] sram_addr1
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic        hit;
   logic        we_q;     // direction of the access in flight
   logic [31:0] rdata_q;  // word captured from the macro at the end of WAIT

   assign hit = wbs_cyc_i && wbs_stb_i &&
                ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational logic below uses blocking (=).
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (hit) state_d = S_ISSUE;
         // The macro samples at the edge ending ISSUE; writes need no data phase.
         S_ISSUE: state_d = we_q ? S_ACK : S_WAIT;
         S_WAIT:  state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;  // stb still high here is deliberately ignored
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------ macro-side registers
   // NOTE: every register here is reset; these are control/data flops, not a
   // memory array, so the reset costs nothing and gives defined macro pins.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         we_q        <= 1'b0;
         rdata_q     <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (hit) begin
                  sram_csb0   <= 1'b0;
                  sram_web0   <= ~wbs_we_i;
                  sram_wmask0 <= wbs_sel_i;  // loaded on reads too; macro ignores it
                  sram_addr0  <= wbs_adr_i[SRAM_AW+1:2];
                  sram_din0   <= wbs_dat_i;
                  we_q        <= wbs_we_i;
               end
            end
            S_ISSUE: begin
               // Chip select is low for exactly the ISSUE cycle.
               sram_csb0 <= 1'b1;
               sram_web0 <= 1'b1;
            end
            S_WAIT: begin
               // dout0 settled after the macro's negedge inside WAIT.
               rdata_q <= sram_dout0;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------- bus outputs
   assign wbs_ack_o = (state_q == S_ACK);
   assign wbs_dat_o = (wbs_ack_o && !we_q) ? rdata_q : 32'h0;

   // ------------------------------------------------------ clocks / port 1
   assign sram_clk0  = wb_clk_i;
   assign sram_clk1  = wb_clk_i;
   assign sram_csb1  = 1'b1;
   assign sram_addr1 = '0;

endmodule

// File: tb/tb_sram_wb_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_wb_port_ctrl
//
// Bench for sram_wb_port_ctrl. A behavioural stand-in for the OpenRAM macro
// samples the port-0 pins at posedge and drives dout0 after the following
// negedge. Expected read data comes from a word-array reference that applies
// each accepted write's byte lanes; expected timing comes from the latency
// rules (write 2, read 3 cycles from the accepting edge).
// -----------------------------------------------------------------------------
module tb_sram_wb_port_ctrl;

   localparam logic [31:0] BASE_ADDR = 32'h3000_0000;
   localparam logic [31:0] ADDR_MASK = 32'hFFFF_F800;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        sram_clk0, sram_clk1;
   logic        sram_csb0, sram_web0, sram_csb1;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0, sram_addr1;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0 = 32'h0;

   sram_wb_port_ctrl dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .sram_clk0  (sram_clk0),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_wmask0(sram_wmask0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0),
      .sram_clk1  (sram_clk1),
      .sram_csb1  (sram_csb1),
      .sram_addr1 (sram_addr1)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------ behavioural macro model
   logic [31:0] mac_mem [512];
   logic        m_csb, m_web;
   logic [3:0]  m_wm;
   logic [8:0]  m_addr, rd_addr;
   logic [31:0] m_din;
   logic        rd_pend = 1'b0;
   int          acc_cnt = 0;
   int          ack_cnt = 0;
   logic        last_web;
   logic [3:0]  last_wm;
   logic [8:0]  last_addr;
   logic [31:0] last_din;

   // Pins are latched mid-cycle so the posedge process sees pre-edge values.
   always @(negedge wb_clk_i) begin
      m_csb  = sram_csb0;
      m_web  = sram_web0;
      m_wm   = sram_wmask0;
      m_addr = sram_addr0;
      m_din  = sram_din0;
      if (rd_pend) sram_dout0 = mac_mem[rd_addr];
      if (wbs_ack_o === 1'b1) ack_cnt++;
   end

   always @(posedge wb_clk_i) begin
      rd_pend = 1'b0;
      if (m_csb === 1'b0) begin
         acc_cnt++;
         last_web  = m_web;
         last_wm   = m_wm;
         last_addr = m_addr;
         last_din  = m_din;
         if (m_web === 1'b0) begin
            for (int b = 0; b < 4; b++)
               if (m_wm[b]) mac_mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
         end else begin
            rd_pend = 1'b1;
            rd_addr = m_addr;
         end
      end
   end

   // -------------------------------------------------------- reference model
   logic [31:0] ref_mem [512];

   initial begin
      for (int i = 0; i < 512; i++) begin
         mac_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
   end

   // One Wishbone transaction. The master holds cyc/stb until it samples ack
   // (so stb is still high during the ACK cycle), then the bus idles 3 cycles
   // before macro accesses and ack pulses are counted.
   task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat,
                      output logic [31:0] rd);
      logic        hit;
      int          lat, n, a0, k0;
      logic [8:0]  word;
      logic [31:0] exp_rd;
      hit    = ((adr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
      word   = adr[10:2];
      lat    = we ? 2 : 3;
      exp_rd = ref_mem[word];
      rd     = 32'h0;
      n      = 0;
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
      a0 = acc_cnt;
      k0 = ack_cnt;
      @(posedge wb_clk_i);  // accepting edge
      // Master samples ack at edge accept+lat, so ack is visible after edge accept+lat-1.
      for (int i = 1; i <= 10; i++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o === 1'b1) begin
            n  = i;
            rd = wbs_dat_o;
            break;
         end
      end
      if (hit) begin
         check({tag, "_ack_latency"}, n, lat - 1);
         check({tag, "_dat_o"}, rd, we ? 32'h0 : exp_rd);
         @(posedge wb_clk_i); #1;
      end else begin
         check({tag, "_miss_no_ack"}, n, 0);
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      check({tag, "_macro_accesses"}, acc_cnt - a0, hit ? 1 : 0);
      check({tag, "_ack_pulses"},     ack_cnt - k0, hit ? 1 : 0);
      if (hit) begin
         check({tag, "_addr0"},  last_addr, word);
         check({tag, "_web0"},   last_web, !we);
         check({tag, "_wmask0"}, last_wm, sel);
         if (we) begin
            check({tag, "_din0"}, last_din, dat);
            for (int b = 0; b < 4; b++)
               if (sel[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
         end
      end
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [31:0] rd, adr, dat;
      logic        we, miss;
      logic [3:0]  sel;
      int          k0;

      wb_rst_i = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;

      // Reset values
      repeat (3) @(posedge wb_clk_i);
      #1;
      check("rst_ctrl", {wbs_ack_o, sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b1, 1'b1, 4'h0, 9'h0});
      check("rst_data", {sram_din0, wbs_dat_o}, 64'h0);
      check("rst_port1", {sram_csb1, sram_addr1}, {1'b1, 9'h0});
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      // Full-word write then read back
      txn("wr_deadbeef", 1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, rd);
      txn("rd_deadbeef", 1'b0, 32'h3000_0010, 4'hF, 32'h0, rd);
      check("rd_deadbeef_const", rd, 32'hDEAD_BEEF);

      // Single-byte write on lane 1
      txn("wr_byte1", 1'b1, 32'h3000_0010, 4'b0010, 32'h0000_AA00, rd);
      txn("rd_byte1", 1'b0, 32'h3000_0010, 4'hF, 32'h0, rd);
      check("rd_byte1_const", rd, 32'hDEAD_AAEF);

      // Top word of the window, then first address past it
      txn("wr_top", 1'b1, 32'h3000_07FC, 4'hF, 32'h5A5A_C3C3, rd);
      txn("rd_top", 1'b0, 32'h3000_07FC, 4'hF, 32'h0, rd);
      check("rd_top_const", rd, 32'h5A5A_C3C3);
      txn("rd_out_of_window", 1'b0, 32'h3000_0800, 4'hF, 32'h0, rd);

      // Reset asserted during WAIT of a read
      k0 = ack_cnt;
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = 32'h3000_0010; wbs_sel_i = 4'hF;
      @(posedge wb_clk_i);  // accept -> ISSUE
      @(posedge wb_clk_i);  // -> WAIT
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge wb_clk_i); #1;
      check("rst_wait_ctrl", {wbs_ack_o, sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b1, 1'b1, 4'h0, 9'h0});
      check("rst_wait_data", {sram_din0, wbs_dat_o}, 64'h0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (5) @(negedge wb_clk_i);
      check("rst_wait_no_ack", ack_cnt - k0, 0);
      txn("rd_after_rst", 1'b0, 32'h3000_0010, 4'hF, 32'h0, rd);

      // Idle bus
      for (int i = 0; i < 20; i++) begin
         @(negedge wb_clk_i);
         check("idle_bus", {sram_csb0, sram_csb1, wbs_ack_o, wbs_dat_o}, {1'b1, 1'b1, 1'b0, 32'h0});
      end

      // Randomized traffic on a small word pool, with occasional misses
      for (int i = 0; i < 40; i++) begin
         we   = 1'($urandom_range(0, 1));
         sel  = 4'($urandom_range(0, 15));
         dat  = $urandom;
         miss = ($urandom_range(0, 7) == 0);
         if (miss) adr = 32'h3000_0800 + (32'($urandom_range(0, 511)) << 2);
         else      adr = BASE_ADDR + (32'($urandom_range(32, 47)) << 2) + 32'($urandom_range(0, 3));
         txn("rand", we, adr, sel, dat, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
